axi_master_bridge: RTL and testbench
====================================

Name: axi_master_bridge

Overview:
- AXI4 initiator that turns a simple core-side burst request (address, length, direction) into one AXI read or write burst on a 32-bit data bus.
- Its AXI port attaches to a bus slave port such as the SRAM wrapper. Its core side serves cache-line refills and write-backs.
- Only one transaction is in flight at a time. Streaming beat interfaces carry write and read data.

Parameters:
- ID_BITS, 4, width of AWID/ARID/BID/RID.
- MASTER_ID, 0, constant ID driven on AWID_M/ARID_M and expected back on BID_M/RID_M.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  bridge can accept a request.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_len  in  4  AXI LEN (beats - 1).
- wd_valid  in  1  write beat valid.
- wd_ready  out  1  write beat accepted.
- wd_data  in  32  write beat data.
- wd_strb  in  4  write beat byte strobes.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  core accepts read beat.
- rd_data  out  32  read beat data.
- rd_last  out  1  final read beat.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  completion had an error; valid with resp_valid.
- AWID_M/AWADDR_M/AWLEN_M/AWSIZE_M/AWBURST_M/AWVALID_M  out  ID_BITS/32/4/3/2/1.
- AWREADY_M  in  1.
- WDATA_M/WSTRB_M/WLAST_M/WVALID_M  out  32/4/1/1.
- WREADY_M  in  1.
- BID_M/BRESP_M/BVALID_M  in  ID_BITS/2/1.
- BREADY_M  out  1.
- ARID_M/ARADDR_M/ARLEN_M/ARSIZE_M/ARBURST_M/ARVALID_M  out  ID_BITS/32/4/3/2/1.
- ARREADY_M  in  1.
- RID_M/RDATA_M/RRESP_M/RLAST_M/RVALID_M  in  ID_BITS/32/2/1/1.
- RREADY_M  out  1.

Behaviour:
- States: IDLE, AR, R, AW, W, B, DONE.
- Reset: state IDLE, all counters and latched fields 0.
  - All VALID outputs, BREADY_M, RREADY_M, wd_ready, rd_valid, resp_valid and resp_err are 0.
  - req_ready is 1 in IDLE.
  - Asserting ARESET mid-burst aborts the burst: next cycle state is IDLE with no completion pulse. Outstanding beats are not drained.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch the following: {req_addr[31:2],2'b00}, req_len, req_write, and err=0. Clear beat_cnt.
  - Next state is AW if req_write, else AR.
- Constant fields: AxSIZE=3'b010, AxBURST=2'b01 (INCR), AxID=MASTER_ID. AxADDR and AxLEN come from the latched values and are stable while VALID is high.
- AW: AWVALID_M=1 until AWREADY_M; then W. First AWVALID_M is the cycle after request acceptance.
- W: W starts only after AW has completed.
  - Pass-through: WVALID_M=wd_valid, wd_ready=WREADY_M, WDATA_M=wd_data, WSTRB_M=wd_strb.
  - WLAST_M = (beat_cnt==len).
  - Each W handshake increments beat_cnt. The handshake with WLAST_M=1 moves to B.
- B: BREADY_M=1.
  - On BVALID_M, err |= (BRESP_M!=2'b00) | (BID_M!=MASTER_ID).
  - Then DONE.
- AR: ARVALID_M=1 until ARREADY_M; then R.
- R: pass-through RREADY_M=rd_ready, rd_valid=RVALID_M, rd_data=RDATA_M, rd_last=RLAST_M.
  - Each R handshake increments beat_cnt.
  - Each R handshake sets err if RRESP_M!=OKAY, RID_M!=MASTER_ID, or RLAST_M != (beat_cnt==len).
  - The handshake at beat_cnt==len moves to DONE, regardless of RLAST_M.
- DONE: resp_valid=1 and resp_err=err for exactly one cycle; next state IDLE.
  - req_ready is 0 in all states except IDLE, so back-to-back requests are spaced by at least the DONE cycle.
- beat_cnt is 4 bits. len=15 gives 16 beats with no overflow, since completion occurs at beat_cnt==15.
- Outside the relevant states, all handshake outputs are 0. Data outputs may hold any value.
- No combinational path exists from req_* to AXI VALIDs; AXI VALIDs come from registered state.

Test Plan:
- Single read: req_write=0, addr=0x0000_1004, len=0; slave ARREADY immediate, returns RDATA=0xDEADBEEF, RLAST=1, RRESP=0 -> ARADDR_M=0x1004, ARLEN_M=0, ARSIZE_M=2; rd_valid with 0xDEADBEEF, rd_last=1; resp_valid one cycle later with resp_err=0.
- Write burst: addr=0x2000, len=3, data 0x11,0x22,0x33,0x44, strb 4'hF; WREADY_M toggling 1,0,1 -> four W handshakes in order, WLAST_M only on 0x44; BREADY_M=1 after last beat; resp_err=0.
- Read burst with backpressure: len=7, rd_ready low every other cycle -> RREADY_M follows rd_ready; 8 beats delivered in order; DONE after the 8th handshake.
- Error response: write with BRESP=2'b10 -> resp_valid=1, resp_err=1. Read with RLAST_M asserted on beat 2 of len=3 -> resp_err=1, still completes after 4 beats.
- Reset mid-burst: ARESET high during the 3rd beat of a len=7 read -> next cycle all VALID/READY outputs 0 except req_ready=1; no resp_valid.
- AR stall and back-to-back: ARREADY_M low for 5 cycles -> ARVALID_M held with ARADDR_M stable. Back-to-back read then write -> req_ready is 0 from acceptance through DONE and 1 the cycle after.

Source files
------------

// File: rtl/axi_master_bridge.sv
// AXI4 initiator: turns one core-side burst request into a single AXI read or
// write burst on a 32-bit bus, with streaming beat interfaces on the core side.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a core request; address/len/err latched on accept
// AR     | read address offered, waiting for ARREADY_M
// R      | read beats pass through to the core, beats counted
// AW     | write address offered, waiting for AWREADY_M
// W      | write beats pass through from the core, WLAST on beat len
// B      | waiting for the write response
// DONE   | one-cycle completion pulse with accumulated error
module axi_master_bridge #(
   parameter int ID_BITS   = 4,
   parameter int MASTER_ID = 0
) (
   input  logic               ACLK,
   input  logic               ARESET,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [31:0]        req_addr,
   input  logic [3:0]         req_len,
   input  logic               wd_valid,
   output logic               wd_ready,
   input  logic [31:0]        wd_data,
   input  logic [3:0]         wd_strb,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic [31:0]        rd_data,
   output logic               rd_last,
   output logic               resp_valid,
   output logic               resp_err,
   output logic [ID_BITS-1:0] AWID_M,
   output logic [31:0]        AWADDR_M,
   output logic [3:0]         AWLEN_M,
   output logic [2:0]         AWSIZE_M,
   output logic [1:0]         AWBURST_M,
   output logic               AWVALID_M,
   input  logic               AWREADY_M,
   output logic [31:0]        WDATA_M,
   output logic [3:0]         WSTRB_M,
   output logic               WLAST_M,
   output logic               WVALID_M,
   input  logic               WREADY_M,
   input  logic [ID_BITS-1:0] BID_M,
   input  logic [1:0]         BRESP_M,
   input  logic               BVALID_M,
   output logic               BREADY_M,
   output logic [ID_BITS-1:0] ARID_M,
   output logic [31:0]        ARADDR_M,
   output logic [3:0]         ARLEN_M,
   output logic [2:0]         ARSIZE_M,
   output logic [1:0]         ARBURST_M,
   output logic               ARVALID_M,
   input  logic               ARREADY_M,
   input  logic [ID_BITS-1:0] RID_M,
   input  logic [31:0]        RDATA_M,
   input  logic [1:0]         RRESP_M,
   input  logic               RLAST_M,
   input  logic               RVALID_M,
   output logic               RREADY_M
);

   localparam logic [ID_BITS-1:0] MID = ID_BITS'(MASTER_ID);

   typedef enum logic [2:0] {
      S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
   } state_t;

   state_t      state_q;
   logic [31:0] addr_q;
   logic [3:0]  len_q;
   logic [3:0]  beat_cnt_q;
   logic        err_q;

   logic last_beat;
   logic w_hs;
   logic r_hs;

   assign last_beat = (beat_cnt_q == len_q);
   assign w_hs      = (state_q == S_W) && wd_valid && WREADY_M;
   assign r_hs      = (state_q == S_R) && RVALID_M && rd_ready;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (req_valid) begin
               addr_q     <= req_addr & 32'hFFFF_FFFC;
               len_q      <= req_len;
               beat_cnt_q <= '0;
               err_q      <= 1'b0;
               state_q    <= req_write ? S_AW : S_AR;
            end
            S_AW: if (AWREADY_M) state_q <= S_W;
            S_W: if (w_hs) begin
               beat_cnt_q <= beat_cnt_q + 4'd1;
               if (last_beat) state_q <= S_B;
            end
            S_B: if (BVALID_M) begin
               err_q   <= err_q | (BRESP_M != 2'b00) | (BID_M != MID);
               state_q <= S_DONE;
            end
            S_AR: if (ARREADY_M) state_q <= S_R;
            // The beat count, not RLAST_M, ends the burst; a misplaced RLAST_M only flags an error.
            S_R: if (r_hs) begin
               beat_cnt_q <= beat_cnt_q + 4'd1;
               err_q      <= err_q | (RRESP_M != 2'b00) | (RID_M != MID) | (RLAST_M != last_beat);
               if (last_beat) state_q <= S_DONE;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_DONE);
   assign resp_err   = (state_q == S_DONE) && err_q;

   assign AWID_M    = MID;
   assign AWADDR_M  = addr_q;
   assign AWLEN_M   = len_q;
   assign AWSIZE_M  = 3'b010;
   assign AWBURST_M = 2'b01;
   assign AWVALID_M = (state_q == S_AW);

   assign WDATA_M  = wd_data;
   assign WSTRB_M  = wd_strb;
   assign WLAST_M  = (state_q == S_W) && last_beat;
   assign WVALID_M = (state_q == S_W) && wd_valid;
   assign wd_ready = (state_q == S_W) && WREADY_M;
   assign BREADY_M = (state_q == S_B);

   assign ARID_M    = MID;
   assign ARADDR_M  = addr_q;
   assign ARLEN_M   = len_q;
   assign ARSIZE_M  = 3'b010;
   assign ARBURST_M = 2'b01;
   assign ARVALID_M = (state_q == S_AR);

   assign RREADY_M = (state_q == S_R) && rd_ready;
   assign rd_valid = (state_q == S_R) && RVALID_M;
   assign rd_data  = RDATA_M;
   assign rd_last  = (state_q == S_R) && RLAST_M;

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed bench for axi_master_bridge: a table of whole transactions driven by
// a small slave model, plus hand-written reset and stall sequences.
module tb_axi_master_bridge;
   localparam int IDB = 4;

   logic            ACLK = 1'b0;
   logic            ARESET;
   logic            req_valid, req_ready, req_write;
   logic [31:0]     req_addr;
   logic [3:0]      req_len;
   logic            wd_valid, wd_ready;
   logic [31:0]     wd_data;
   logic [3:0]      wd_strb;
   logic            rd_valid, rd_ready, rd_last;
   logic [31:0]     rd_data;
   logic            resp_valid, resp_err;
   logic [IDB-1:0]  AWID_M, BID_M, ARID_M, RID_M;
   logic [31:0]     AWADDR_M, ARADDR_M, WDATA_M, RDATA_M;
   logic [3:0]      AWLEN_M, ARLEN_M, WSTRB_M;
   logic [2:0]      AWSIZE_M, ARSIZE_M;
   logic [1:0]      AWBURST_M, ARBURST_M, BRESP_M, RRESP_M;
   logic            AWVALID_M, AWREADY_M, WLAST_M, WVALID_M, WREADY_M;
   logic            BVALID_M, BREADY_M, ARVALID_M, ARREADY_M;
   logic            RLAST_M, RVALID_M, RREADY_M;

   axi_master_bridge #(.ID_BITS(IDB), .MASTER_ID(0)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .resp_valid(resp_valid), .resp_err(resp_err),
      .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
      .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
      .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
      .WREADY_M(WREADY_M),
      .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M),
      .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
      .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
      .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
      .RVALID_M(RVALID_M), .RREADY_M(RREADY_M)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [1:0]  resp;
      logic [3:0]  id;
      int          bad_last;   // beat carrying RLAST_M, -1 for the correct beat
      int          stall;      // cycles of AxREADY low
      logic        throttle;   // toggle WREADY_M (write) or rd_ready (read)
      logic [31:0] exp_addr;
      logic        exp_err;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs[NV];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
      end
   endtask

   task automatic budget_fail(input string nm);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=handshake", nm);
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic quiet_inputs();
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
      wd_valid = 1'b0; wd_data = '0; wd_strb = '0; rd_ready = 1'b0;
      AWREADY_M = 1'b0; WREADY_M = 1'b0; ARREADY_M = 1'b0;
      BID_M = '0; BRESP_M = '0; BVALID_M = 1'b0;
      RID_M = '0; RDATA_M = '0; RRESP_M = '0; RLAST_M = 1'b0; RVALID_M = 1'b0;
   endtask

   task automatic chk_all_idle(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_valids"}, 32'({AWVALID_M, WVALID_M, ARVALID_M, rd_valid, resp_valid}), 32'd0);
      chk({tag, "_readies"}, 32'({BREADY_M, RREADY_M, wd_ready, resp_err}), 32'd0);
   endtask

   task automatic run_txn(input vec_t v);
      int i;
      int cyc;
      req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_len = v.len;
      #1;
      chk("accept_req_ready", 32'(req_ready), 32'd1);
      chk("accept_resp_valid", 32'(resp_valid), 32'd0);
      chk("accept_axvalid", 32'({AWVALID_M, ARVALID_M}), 32'd0);
      tick();
      // scramble the request fields to prove the bridge latched them
      req_valid = 1'b0; req_write = ~v.wr; req_addr = 32'hFFFF_FFFF; req_len = ~v.len;
      if (v.wr) begin
         wd_valid = 1'b1; WREADY_M = 1'b1; wd_data = 32'hBAD0_BAD0; wd_strb = 4'h5;
         for (int s = 0; s <= v.stall; s++) begin
            AWREADY_M = (s == v.stall);
            #1;
            chk("awvalid", 32'(AWVALID_M), 32'd1);
            chk("awaddr", AWADDR_M, v.exp_addr);
            chk("awlen", 32'(AWLEN_M), 32'(v.len));
            chk("awconst", 32'({AWID_M, AWSIZE_M, AWBURST_M}), 32'({4'h0, 3'b010, 2'b01}));
            chk("w_before_aw", 32'({WVALID_M, wd_ready}), 32'd0);
            chk("busy_req_ready", 32'(req_ready), 32'd0);
            tick();
         end
         AWREADY_M = 1'b0;
         i = 0; cyc = 0;
         while (i <= int'(v.len) && cyc < 64) begin
            wd_valid = 1'b1;
            wd_data  = 32'h11 * 32'(i + 1);
            wd_strb  = 4'hF - 4'(i);
            WREADY_M = v.throttle ? ~cyc[0] : 1'b1;
            #1;
            chk("wvalid", 32'(WVALID_M), 32'd1);
            chk("wdata", WDATA_M, 32'h11 * 32'(i + 1));
            chk("wstrb", 32'(WSTRB_M), 32'(4'hF - 4'(i)));
            chk("wd_ready", 32'(wd_ready), 32'(WREADY_M));
            chk("wlast", 32'(WLAST_M), 32'(i == int'(v.len)));
            chk("aw_dropped", 32'({AWVALID_M, BREADY_M}), 32'd0);
            if (WREADY_M) i++;
            cyc++;
            tick();
         end
         if (cyc >= 64) budget_fail("w_budget");
         wd_valid = 1'b0; WREADY_M = 1'b0;
         #1;
         chk("bready_wait", 32'(BREADY_M), 32'd1);
         chk("b_no_resp", 32'(resp_valid), 32'd0);
         tick();
         BVALID_M = 1'b1; BRESP_M = v.resp; BID_M = v.id;
         #1;
         chk("bready_hs", 32'(BREADY_M), 32'd1);
         tick();
      end else begin
         rd_ready = 1'b1; RVALID_M = 1'b1; RDATA_M = 32'hBAD0_BAD0;
         for (int s = 0; s <= v.stall; s++) begin
            ARREADY_M = (s == v.stall);
            #1;
            chk("arvalid", 32'(ARVALID_M), 32'd1);
            chk("araddr", ARADDR_M, v.exp_addr);
            chk("arlen", 32'(ARLEN_M), 32'(v.len));
            chk("arconst", 32'({ARID_M, ARSIZE_M, ARBURST_M}), 32'({4'h0, 3'b010, 2'b01}));
            chk("r_before_ar", 32'({RREADY_M, rd_valid}), 32'd0);
            chk("busy_req_ready", 32'(req_ready), 32'd0);
            tick();
         end
         ARREADY_M = 1'b0;
         i = 0; cyc = 0;
         while (i <= int'(v.len) && cyc < 64) begin
            rd_ready = v.throttle ? ~cyc[0] : 1'b1;
            RVALID_M = 1'b1;
            RDATA_M  = 32'hDEADBEEF + 32'(i);
            RLAST_M  = (v.bad_last >= 0) ? (i == v.bad_last) : (i == int'(v.len));
            RRESP_M  = v.resp;
            RID_M    = v.id;
            #1;
            chk("rready", 32'(RREADY_M), 32'(rd_ready));
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_data", rd_data, 32'hDEADBEEF + 32'(i));
            chk("rd_last", 32'(rd_last), 32'(RLAST_M));
            chk("r_no_resp", 32'({ARVALID_M, resp_valid}), 32'd0);
            if (rd_ready) i++;
            cyc++;
            tick();
         end
         if (cyc >= 64) budget_fail("r_budget");
      end
      quiet_inputs();
      #1;
      chk("done_resp_valid", 32'(resp_valid), 32'd1);
      chk("done_resp_err", 32'(resp_err), 32'(v.exp_err));
      chk("done_req_ready", 32'(req_ready), 32'd0);
      chk("done_handshakes", 32'({BREADY_M, RREADY_M, AWVALID_M, ARVALID_M}), 32'd0);
      tick();
   endtask

   initial begin
      //         wr    addr          len   resp   id    bad  stl thr  exp_addr      err
      vecs[0]  = '{1'b0, 32'h0000_1004, 4'd0,  2'b00, 4'h0, -1, 0, 1'b0, 32'h0000_1004, 1'b0};
      vecs[1]  = '{1'b1, 32'h0000_2000, 4'd3,  2'b00, 4'h0, -1, 0, 1'b1, 32'h0000_2000, 1'b0};
      vecs[2]  = '{1'b0, 32'h0000_3000, 4'd7,  2'b00, 4'h0, -1, 0, 1'b1, 32'h0000_3000, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_4008, 4'd1,  2'b10, 4'h0, -1, 0, 1'b0, 32'h0000_4008, 1'b1};
      vecs[4]  = '{1'b0, 32'h0000_5000, 4'd3,  2'b00, 4'h0,  2, 0, 1'b0, 32'h0000_5000, 1'b1};
      vecs[5]  = '{1'b0, 32'h0000_6003, 4'd15, 2'b00, 4'h0, -1, 0, 1'b0, 32'h0000_6000, 1'b0};
      vecs[6]  = '{1'b0, 32'h0000_7000, 4'd0,  2'b00, 4'h1, -1, 0, 1'b0, 32'h0000_7000, 1'b1};
      vecs[7]  = '{1'b1, 32'h0000_8001, 4'd0,  2'b00, 4'h3, -1, 2, 1'b0, 32'h0000_8000, 1'b1};
      vecs[8]  = '{1'b0, 32'h0000_9000, 4'd2,  2'b00, 4'h0, -1, 5, 1'b0, 32'h0000_9000, 1'b0};
      vecs[9]  = '{1'b1, 32'h0000_A00C, 4'd15, 2'b00, 4'h0, -1, 0, 1'b1, 32'h0000_A00C, 1'b0};
      vecs[10] = '{1'b0, 32'hFFFF_FFFE, 4'd1,  2'b10, 4'h0, -1, 0, 1'b0, 32'hFFFF_FFFC, 1'b1};

      quiet_inputs();
      ARESET = 1'b1;
      tick();
      tick();
      chk_all_idle("reset");
      ARESET = 1'b0;
      tick();
      chk_all_idle("post_reset");

      // back-to-back: each transaction starts the cycle after the previous DONE
      for (int n = 0; n < NV; n++) run_txn(vecs[n]);

      // reset during the third beat of an 8-beat read
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0100; req_len = 4'd7;
      tick();
      quiet_inputs();
      ARREADY_M = 1'b1;
      #1;
      chk("rst_seq_arvalid", 32'(ARVALID_M), 32'd1);
      tick();
      ARREADY_M = 1'b0;
      for (int b = 0; b < 2; b++) begin
         rd_ready = 1'b1; RVALID_M = 1'b1; RDATA_M = 32'h5A5A_0000 + 32'(b);
         #1;
         chk("rst_seq_rd_valid", 32'(rd_valid), 32'd1);
         tick();
      end
      rd_ready = 1'b1; RVALID_M = 1'b1; RDATA_M = 32'h5A5A_0002; ARESET = 1'b1;
      #1;
      chk("rst_seq_beat3", 32'(RREADY_M), 32'd1);
      tick();
      chk_all_idle("mid_reset");
      ARESET = 1'b0;
      RVALID_M = 1'b0;
      tick();
      chk_all_idle("after_abort");

      // bridge recovers with a normal transaction after the abort
      run_txn(vecs[0]);
      run_txn(vecs[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "bench timeout");
   end
endmodule
